// File: rtl/regfile_bypass.sv
// regfile_bypass: DEPTH x WIDTH register file, one write port, two independent read ports.
// Latency: writes commit on the rising clk edge (1 cycle); reads are combinational, with optional same-cycle forwarding.
// Backpressure: none; a write is accepted every cycle and the last write to an address wins.
module regfile_bypass #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 32,
  parameter bit ZERO_EN = 1'b1,
  parameter bit BYPASS  = 1'b1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [AW-1:0]    WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [AW-1:0]    ReadRegister1,
  input  logic [AW-1:0]    ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  // Address of the hardwired-zero entry (only meaningful when ZERO_EN is set).
  localparam logic [AW-1:0] ZERO_ADDR = AW'(DEPTH - 1);
  // DEPTH widened by one bit so out-of-range checks work even when DEPTH == 2**AW.
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];

  logic wr_in_range;
  logic wr_to_zero;
  logic wr_commit;
  logic wr_fwd;
  logic rd1_zero;
  logic rd2_zero;
  logic rd1_hit;
  logic rd2_hit;

  // Linear lookup keeps every index inside the array for non-power-of-two depths.
  function automatic logic [WIDTH-1:0] stored_at(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == i[AW-1:0]) val = regs[i];
    end
    return val;
  endfunction

  // An address reads as zero if it lies beyond the array or names the hardwired-zero entry.
  function automatic logic forced_zero(input logic [AW-1:0] addr);
    return ({1'b0, addr} >= DEPTH_EXT) || (ZERO_EN && (addr == ZERO_ADDR));
  endfunction

  // Qualify the write: reset, out-of-range and hardwired-zero targets are all dropped.
  always_comb begin
    wr_in_range = {1'b0, WriteRegister} < DEPTH_EXT;
    wr_to_zero  = ZERO_EN && (WriteRegister == ZERO_ADDR);
    wr_commit   = RegWrite && !reset && wr_in_range && !wr_to_zero;
    wr_fwd      = BYPASS && wr_commit;
  end

  // Storage: reset clears every entry and beats any write; otherwise only the addressed entry loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_commit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (WriteRegister == i[AW-1:0]) regs[i] <= WriteData;
      end
    end
  end

  // Per-port classification: forced zero and forward-hit, evaluated independently for each port.
  always_comb begin
    rd1_zero = forced_zero(ReadRegister1);
    rd2_zero = forced_zero(ReadRegister2);
    rd1_hit  = wr_fwd && (ReadRegister1 == WriteRegister);
    rd2_hit  = wr_fwd && (ReadRegister2 == WriteRegister);
  end

  // Read port 1: forced zero beats forwarding, forwarding beats stored contents.
  always_comb begin
    if (rd1_zero)     ReadData1 = '0;
    else if (rd1_hit) ReadData1 = WriteData;
    else              ReadData1 = stored_at(ReadRegister1);
  end

  // Read port 2: same priority as port 1, fully independent of it.
  always_comb begin
    if (rd2_zero)     ReadData2 = '0;
    else if (rd2_hit) ReadData2 = WriteData;
    else              ReadData2 = stored_at(ReadRegister2);
  end

endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: checks four configurations of regfile_bypass against a behavioural model.
// Default config (64x32, zero reg, forwarding) also gets a hand-derived vector table.
// Expected values are queued when inputs are driven and compared at the following negedge.
module tb_regfile_bypass;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [63:0] d_rd1, d_rd2, n_rd1, n_rd2, z_rd1, z_rd2;

  logic        s_we;
  logic [3:0]  s_wa;
  logic [7:0]  s_wd;
  logic [3:0]  s_ra1;
  logic [3:0]  s_ra2;
  logic [7:0]  s_rd1, s_rd2;

  regfile_bypass u_dut (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
    .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(d_rd1), .ReadData2(d_rd2)
  );

  regfile_bypass #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
    .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(n_rd1), .ReadData2(n_rd2)
  );

  regfile_bypass #(.ZERO_EN(1'b0)) u_nz (
    .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
    .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(z_rd1), .ReadData2(z_rd2)
  );

  regfile_bypass #(.WIDTH(8), .DEPTH(12)) u_sm (
    .clk(clk), .reset(reset), .RegWrite(s_we), .WriteRegister(s_wa), .WriteData(s_wd),
    .ReadRegister1(s_ra1), .ReadRegister2(s_ra2), .ReadData1(s_rd1), .ReadData2(s_rd2)
  );

  // Reference contents: m1 for ZERO_EN=1 instances, m0 for ZERO_EN=0, ms for the 8x12 instance.
  logic [63:0] m1 [32];
  logic [63:0] m0 [32];
  logic [7:0]  ms [12];

  typedef struct {
    int          id;
    logic [63:0] exp;
  } sb_t;

  sb_t   sbq[$];
  int    total = 0;
  int    bad   = 0;
  string cur   = "";
  string names [8] = '{"dut_rd1", "dut_rd2", "nobyp_rd1", "nobyp_rd2",
                       "nozero_rd1", "nozero_rd2", "small_rd1", "small_rd2"};

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  // Expected read from a 64x32 instance, derived from the read priority rules.
  function automatic logic [63:0] exp_big(input bit zen, input bit byp, input int a);
    if (zen && a == 31) return 64'd0;
    if (byp && we && !reset && int'(wa) == a && !(zen && wa == 5'd31)) return wd;
    return zen ? m1[a] : m0[a];
  endfunction

  // Expected read from the 8x12 instance (entry 11 is the zero register, 12..15 out of range).
  function automatic logic [63:0] exp_sm(input int a);
    if (a >= 11) return 64'd0;
    if (s_we && !reset && int'(s_wa) == a) return {56'd0, s_wd};
    return {56'd0, ms[a]};
  endfunction

  function automatic logic [63:0] actual(input int id);
    case (id)
      0:       return d_rd1;
      1:       return d_rd2;
      2:       return n_rd1;
      3:       return n_rd2;
      4:       return z_rd1;
      5:       return z_rd2;
      6:       return {56'd0, s_rd1};
      default: return {56'd0, s_rd2};
    endcase
  endfunction

  task automatic push(input int id, input logic [63:0] exp);
    sb_t e;
    e.id  = id;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic check_all();
    sb_t         e;
    logic [63:0] act;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = actual(e.id);
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s %s: got %h want %h", cur, names[e.id], act, e.exp);
      end
    end
  endtask

  task automatic update_model();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m1[i] = 64'd0;
        m0[i] = 64'd0;
      end
      for (int i = 0; i < 12; i++) ms[i] = 8'd0;
    end else begin
      if (we) begin
        if (wa != 5'd31) m1[int'(wa)] = wd;
        m0[int'(wa)] = wd;
      end
      if (s_we && int'(s_wa) < 11) ms[int'(s_wa)] = s_wd;
    end
  endtask

  // One cycle: inputs are already driven (just after posedge); queue expectations,
  // compare at negedge, then advance the model across the next rising edge.
  task automatic run_cycle(input string tag, input bit tbl, input logic [63:0] t1, input logic [63:0] t2);
    cur = tag;
    if (tbl) begin
      push(0, t1);
      push(1, t2);
    end else begin
      push(0, exp_big(1'b1, 1'b1, int'(ra1)));
      push(1, exp_big(1'b1, 1'b1, int'(ra2)));
    end
    push(2, exp_big(1'b1, 1'b0, int'(ra1)));
    push(3, exp_big(1'b1, 1'b0, int'(ra2)));
    push(4, exp_big(1'b0, 1'b1, int'(ra1)));
    push(5, exp_big(1'b0, 1'b1, int'(ra2)));
    push(6, exp_sm(int'(s_ra1)));
    push(7, exp_sm(int'(s_ra2)));
    @(negedge clk);
    check_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  initial begin
    // Hand-derived expectations for the default configuration.
    //          rst   we    wa     wd                        ra1    ra2    e1                        e2
    vt[0]  = '{1'b1, 1'b1, 5'd3,  64'h1,                    5'd3,  5'd0,  64'h0,                    64'h0};
    vt[1]  = '{1'b0, 1'b0, 5'd0,  64'h0,                    5'd3,  5'd31, 64'h0,                    64'h0};
    vt[2]  = '{1'b0, 1'b1, 5'd5,  64'h0123_4567_89AB_CDEF,  5'd5,  5'd4,  64'h0123_4567_89AB_CDEF,  64'h0};
    vt[3]  = '{1'b0, 1'b0, 5'd0,  64'h0,                    5'd5,  5'd4,  64'h0123_4567_89AB_CDEF,  64'h0};
    vt[4]  = '{1'b0, 1'b1, 5'd7,  64'hDEAD,                 5'd7,  5'd7,  64'hDEAD,                 64'hDEAD};
    vt[5]  = '{1'b0, 1'b0, 5'd0,  64'h0,                    5'd7,  5'd5,  64'hDEAD,                 64'h0123_4567_89AB_CDEF};
    vt[6]  = '{1'b0, 1'b1, 5'd31, 64'hFFFF,                 5'd31, 5'd31, 64'h0,                    64'h0};
    vt[7]  = '{1'b0, 1'b0, 5'd0,  64'h0,                    5'd31, 5'd7,  64'h0,                    64'hDEAD};
    vt[8]  = '{1'b0, 1'b1, 5'd5,  64'h1111,                 5'd5,  5'd5,  64'h1111,                 64'h1111};
    vt[9]  = '{1'b0, 1'b1, 5'd5,  64'h2222,                 5'd5,  5'd7,  64'h2222,                 64'hDEAD};
    vt[10] = '{1'b0, 1'b0, 5'd0,  64'h0,                    5'd5,  5'd0,  64'h2222,                 64'h0};
    vt[11] = '{1'b0, 1'b1, 5'd0,  64'hAAAA,                 5'd1,  5'd0,  64'h0,                    64'hAAAA};
    vt[12] = '{1'b1, 1'b0, 5'd0,  64'h0,                    5'd5,  5'd7,  64'h2222,                 64'hDEAD};
    vt[13] = '{1'b0, 1'b0, 5'd0,  64'h0,                    5'd5,  5'd7,  64'h0,                    64'h0};
    vt[14] = '{1'b0, 1'b0, 5'd0,  64'h0,                    5'd0,  5'd31, 64'h0,                    64'h0};

    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra1 = '0; s_ra2 = '0;
    for (int i = 0; i < 32; i++) begin
      m1[i] = 64'd0;
      m0[i] = 64'd0;
    end
    for (int i = 0; i < 12; i++) ms[i] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Every address on both ports reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      ra1   = 5'(i);
      ra2   = 5'(31 - i);
      s_ra1 = 4'(i % 16);
      s_ra2 = 4'(15 - (i % 16));
      run_cycle($sformatf("reset_sweep%0d", i), 1'b0, 64'd0, 64'd0);
    end

    // Table of write / forward / zero-register / reset-collision vectors.
    s_ra1 = 4'd0;
    s_ra2 = 4'd11;
    for (int k = 0; k < NV; k++) begin
      reset = vt[k].rst;
      we    = vt[k].we;
      wa    = vt[k].wa;
      wd    = vt[k].wd;
      ra1   = vt[k].ra1;
      ra2   = vt[k].ra2;
      run_cycle($sformatf("vec%0d", k), 1'b1, vt[k].e1, vt[k].e2);
    end
    reset = 1'b0;
    we    = 1'b0;

    // Small instance: an out-of-range write is dropped and the address reads zero.
    s_we = 1'b1; s_wa = 4'd13; s_wd = 8'h5A; s_ra1 = 4'd13; s_ra2 = 4'd0;
    run_cycle("sm_oob_write", 1'b0, 64'd0, 64'd0);
    s_we = 1'b0;
    run_cycle("sm_oob_read", 1'b0, 64'd0, 64'd0);

    // Fill 0..10 with A5 (forwarded in the write cycle), then the zero register refuses a write.
    for (int i = 0; i < 11; i++) begin
      s_we = 1'b1; s_wa = 4'(i); s_wd = 8'hA5; s_ra1 = 4'(i); s_ra2 = 4'd11;
      run_cycle($sformatf("sm_fill%0d", i), 1'b0, 64'd0, 64'd0);
    end
    s_we = 1'b1; s_wa = 4'd11; s_wd = 8'h3C; s_ra1 = 4'd11; s_ra2 = 4'd10;
    run_cycle("sm_zero_write", 1'b0, 64'd0, 64'd0);
    s_we = 1'b0;

    // Read back every address: 0..10 hold A5, 11..15 read zero.
    for (int i = 0; i < 16; i++) begin
      s_ra1 = 4'(i);
      s_ra2 = 4'(15 - i);
      run_cycle($sformatf("sm_readback%0d", i), 1'b0, 64'd0, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
